// File: rtl/asic_bridge_pkg.sv
// Shared constants and types for the ASIC output bridge blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package asic_bridge_pkg;

  // Number of XADC auxiliary channels carrying ASIC outputs
  localparam int NUM_AUX = 4;

  // Defaults shared with the XADC reader and the config registers
  localparam int          DEF_SAMPLE_WIDTH = 12;
  localparam int          DEF_AVG_LOG2     = 3;
  localparam logic [11:0] DEF_MIN_LEVEL    = 12'h100;

  // Classifier sequencing: average -> find argmax -> apply stability filter
  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DECIDE  = 2'd2
  } cls_state_e;

endpackage

// File: rtl/asic_output_classifier_if.sv
// Sample-in / classification-out bundle for the ASIC output classifier.
// Latency: n/a (wiring only).
// Backpressure: none; sample_valid is a strobe the classifier always accepts.
interface asic_output_classifier_if
  import asic_bridge_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
);
  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] aux0;
  logic [SAMPLE_WIDTH-1:0] aux1;
  logic [SAMPLE_WIDTH-1:0] aux2;
  logic [SAMPLE_WIDTH-1:0] aux3;
  logic [SAMPLE_WIDTH-1:0] avg_aux0;
  logic [SAMPLE_WIDTH-1:0] avg_aux1;
  logic [SAMPLE_WIDTH-1:0] avg_aux2;
  logic [SAMPLE_WIDTH-1:0] avg_aux3;
  logic [1:0]              network_output;
  logic                    output_valid;
  logic                    class_update;
  logic                    no_spike;

  // Sample producer side (XADC reader)
  modport master (
    output sample_valid, aux0, aux1, aux2, aux3,
    input  avg_aux0, avg_aux1, avg_aux2, avg_aux3,
    input  network_output, output_valid, class_update, no_spike
  );

  // Classifier side
  modport slave (
    input  sample_valid, aux0, aux1, aux2, aux3,
    output avg_aux0, avg_aux1, avg_aux2, avg_aux3,
    output network_output, output_valid, class_update, no_spike
  );
endinterface

// File: rtl/asic_output_classifier_aux_window_accumulator.sv
// Box-car accumulator for one AUX channel; emits the truncated window mean.
// Latency: avg updates on the edge that accepts the last sample of a window.
// Backpressure: none; every sample_valid strobe is accumulated.
module aux_window_accumulator
  import asic_bridge_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int AVG_LOG2     = DEF_AVG_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic                    window_end,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [SAMPLE_WIDTH-1:0] avg
);
  // Wide enough for 2^AVG_LOG2 full-scale samples, so no overflow is possible
  localparam int ACC_W = SAMPLE_WIDTH + AVG_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum = acc_q + ACC_W'(sample);

  // Add on each strobe; on the closing sample publish sum>>AVG_LOG2 and restart
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      avg   <= '0;
    end else if (sample_valid) begin
      if (window_end) begin
        avg   <= acc_sum[ACC_W-1:AVG_LOG2];
        acc_q <= '0;
      end else begin
        acc_q <= acc_sum;
      end
    end
  end

endmodule

// File: rtl/asic_output_classifier.sv
// Averages four AUX channels per window, picks the dominant one, commits it once stable.
// Latency: avg_aux* after the window's last-sample edge E; decision outputs after E+2.
// Backpressure: none; samples arriving during COMPARE/DECIDE feed the next window.
module asic_output_classifier
  import asic_bridge_pkg::*;
#(
  parameter int                    SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int                    AVG_LOG2     = DEF_AVG_LOG2,
  parameter int                    STABLE_COUNT = 3,
  parameter logic [SAMPLE_WIDTH-1:0] MIN_LEVEL  = SAMPLE_WIDTH'(DEF_MIN_LEVEL)
) (
  input logic                     clk,
  input logic                     rst,
  asic_output_classifier_if.slave bus
);
  localparam logic [3:0] STABLE_MAX = 4'(STABLE_COUNT);

  logic [SAMPLE_WIDTH-1:0] aux_in [NUM_AUX];
  logic [SAMPLE_WIDTH-1:0] avg    [NUM_AUX];

  logic [AVG_LOG2-1:0] samp_cnt_q;
  logic                window_end;

  cls_state_e state_q, state_d;

  logic [1:0]              arg_idx;
  logic [SAMPLE_WIDTH-1:0] arg_val;
  logic [1:0]              max_idx_q;
  logic [SAMPLE_WIDTH-1:0] max_val_q;

  logic [1:0] cand_q, cand_d;
  logic [3:0] stable_q, stable_d;
  logic       spike;
  logic       commit;

  logic [1:0] net_q;
  logic       out_valid_q;
  logic       class_update_q;
  logic       no_spike_q;

  assign aux_in[0] = bus.aux0;
  assign aux_in[1] = bus.aux1;
  assign aux_in[2] = bus.aux2;
  assign aux_in[3] = bus.aux3;

  // Last sample of the window: the counter is about to wrap
  assign window_end = bus.sample_valid && (samp_cnt_q == '1);

  for (genvar g = 0; g < NUM_AUX; g++) begin : g_acc
    aux_window_accumulator #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .AVG_LOG2    (AVG_LOG2)
    ) u_acc (
      .clk         (clk),
      .rst         (rst),
      .sample_valid(bus.sample_valid),
      .window_end  (window_end),
      .sample      (aux_in[g]),
      .avg         (avg[g])
    );
  end

  // Window sample counter; wraps naturally to 0 after 2^AVG_LOG2 samples
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt_q <= '0;
    end else if (bus.sample_valid) begin
      samp_cnt_q <= samp_cnt_q + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one cycle each for argmax and decision after a window closes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM:   if (window_end) state_d = ST_COMPARE;
      ST_COMPARE: state_d = ST_DECIDE;
      ST_DECIDE:  state_d = ST_ACCUM;
      default:    state_d = ST_ACCUM;
    endcase
  end

  // Argmax over the published averages; strict '>' keeps the lowest index on ties
  always_comb begin
    arg_idx = '0;
    arg_val = avg[0];
    for (int i = 1; i < NUM_AUX; i++) begin
      if (avg[i] > arg_val) begin
        arg_idx = 2'(i);
        arg_val = avg[i];
      end
    end
  end

  // Stability filter: count consecutive identical winners, saturating, and decide on commit
  always_comb begin
    spike    = (max_val_q >= MIN_LEVEL);
    cand_d   = cand_q;
    stable_d = stable_q;
    if ((max_idx_q == cand_q) && (stable_q != 4'd0)) begin
      stable_d = (stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + 4'd1;
    end else begin
      cand_d   = max_idx_q;
      stable_d = 4'd1;
    end
    commit = (stable_d == STABLE_MAX) && ((net_q != cand_d) || !out_valid_q);
  end

  // Decision registers: capture argmax in COMPARE, update filter and outputs in DECIDE
  always_ff @(posedge clk) begin
    if (rst) begin
      max_idx_q      <= '0;
      max_val_q      <= '0;
      cand_q         <= '0;
      stable_q       <= '0;
      net_q          <= '0;
      out_valid_q    <= 1'b0;
      class_update_q <= 1'b0;
      no_spike_q     <= 1'b0;
    end else begin
      class_update_q <= 1'b0;
      if (state_q == ST_COMPARE) begin
        max_idx_q <= arg_idx;
        max_val_q <= arg_val;
      end
      if (state_q == ST_DECIDE) begin
        if (!spike) begin
          no_spike_q <= 1'b1;
          stable_q   <= 4'd0;
        end else begin
          no_spike_q <= 1'b0;
          cand_q     <= cand_d;
          stable_q   <= stable_d;
          if (commit) begin
            net_q          <= cand_d;
            out_valid_q    <= 1'b1;
            class_update_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.avg_aux0       = avg[0];
  assign bus.avg_aux1       = avg[1];
  assign bus.avg_aux2       = avg[2];
  assign bus.avg_aux3       = avg[3];
  assign bus.network_output = net_q;
  assign bus.output_valid   = out_valid_q;
  assign bus.class_update   = class_update_q;
  assign bus.no_spike       = no_spike_q;

endmodule

// File: doc/asic_output_classifier.md
Name: asic_output_classifier

Overview:
- Sits directly downstream of the XADC DRP reader and consumes its four 12-bit auxiliary-channel measurements (AUX0..AUX3) of the neuromorphic ASIC outputs.
- Box-car averages each channel over a window of 2^AVG_LOG2 samples, selects the dominant channel (argmax), and applies a stability filter before committing it.
- Drives network_output into the AXI config registers and the LED logic, and exposes the averaged values for readback.

Parameters:
- SAMPLE_WIDTH, 12, width of each measured AUX sample.
- AVG_LOG2, 3, log2 of the averaging window length. Legal range is 2..6.
- STABLE_COUNT, 3, consecutive windows with the same winner required before network_output updates. Legal range is 1..15.
- MIN_LEVEL, 12'h100, threshold: an averaged maximum below this counts as "no spike".

Ports:
- clk  in  1  system clock (S_AXI_ACLK domain).
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe: aux0..aux3 hold a fresh sample set.
- aux0  in  SAMPLE_WIDTH  measured AUX0.
- aux1  in  SAMPLE_WIDTH  measured AUX1.
- aux2  in  SAMPLE_WIDTH  measured AUX2.
- aux3  in  SAMPLE_WIDTH  measured AUX3.
- avg_aux0  out  SAMPLE_WIDTH  last completed window average, channel 0.
- avg_aux1  out  SAMPLE_WIDTH  last completed window average, channel 1.
- avg_aux2  out  SAMPLE_WIDTH  last completed window average, channel 2.
- avg_aux3  out  SAMPLE_WIDTH  last completed window average, channel 3.
- network_output  out  2  committed winning channel index.
- output_valid  out  1  high once any classification has been committed.
- class_update  out  1  one-cycle pulse when network_output is (re)committed.
- no_spike  out  1  last window's maximum average was below MIN_LEVEL.

Behaviour:
- **Reset.** Every output is 0, accumulators are 0, the sample counter is 0, the candidate and stable_cnt are 0, and the FSM is in ACCUM. A reset mid-window discards the partial sums.
- **Accumulation.**
  - Each channel has an accumulator of SAMPLE_WIDTH+AVG_LOG2 bits. It cannot overflow, since 4095*8 = 32760 fits in 15 bits.
  - On sample_valid the sample is added and the counter increments. This happens in every FSM state.
  - On the sample where the counter equals 2^AVG_LOG2-1:
    - avg_auxN <= (acc+auxN) >> AVG_LOG2, which truncates.
    - The accumulators and counter clear to 0.
    - The FSM goes to COMPARE.
  - The window length is at least 4 samples, so a window can never complete while the FSM is outside ACCUM.
- **FSM states.** ACCUM -> COMPARE -> DECIDE -> ACCUM.
  - COMPARE (1 cycle):
    - Register max_idx, the argmax of the avg_aux values. Ties resolve to the lowest index.
    - Register max_val.
  - DECIDE (1 cycle), no spike case (max_val < MIN_LEVEL):
    - no_spike <= 1 and stable_cnt <= 0.
    - network_output and output_valid are unchanged.
  - DECIDE, spike case: no_spike <= 0, then the stability filter:
    - If max_idx == candidate and stable_cnt != 0, stable_cnt increments, saturating at STABLE_COUNT.
    - Otherwise candidate <= max_idx and stable_cnt <= 1.
  - DECIDE, commit: if the new stable_cnt == STABLE_COUNT, and either network_output != candidate or output_valid == 0:
    - network_output <= candidate.
    - output_valid <= 1.
    - class_update pulses for one cycle.
  - No re-pulse is issued while the winner is unchanged.
- **Latency.** The final sample of a window is accepted at edge E.
  - avg_aux values are visible after E.
  - network_output, class_update and no_spike are visible after E+2.
  - class_update is high exactly during the first cycle of the new network_output value.
- **Simultaneous events.**
  - rst has priority over sample_valid and every FSM action.
  - sample_valid during COMPARE or DECIDE accumulates into the next window without loss.
- **Unknown inputs.** aux values are sampled only when sample_valid is high. Values on other cycles are ignored.

Decomposition:
- Shared package asic_bridge_pkg contains:
  - FSM state encoding (ST_ACCUM, ST_COMPARE, ST_DECIDE).
  - NUM_AUX = 4.
  - Default SAMPLE_WIDTH, AVG_LOG2 and MIN_LEVEL constants, also used by the XADC interface and the config registers.
- One sub-module, aux_window_accumulator, is instantiated 4 times. It holds the accumulator, add-on-valid, clear-on-window-end and the shift-to-average output register.
- The window counter and FSM live in the parent.

Test Plan:
- **Basic commit.** After reset, 3 windows of 8 samples each with aux=(100,900,200,300) -> avg_aux1=900 after each window. No update after windows 1 and 2. After window 3: network_output=1, output_valid=1, and class_update is high for exactly 1 cycle, 2 cycles after the last sample edge.
- **Truncation.** aux0 alternates 0,7 for 8 samples -> sum 28, avg_aux0=3.
- **Tie-break.** All channels =500 for 3 windows -> network_output=0 and class_update pulses once.
- **Below threshold.** Starting committed at 1, one window with all channels ≤255 -> no_spike=1, network_output stays 1, stable_cnt resets. The next two class-1 windows give no pulse, because the winner is unchanged.
- **Class change.** Committed at 1, then windows of aux=(0,0,1000,0): after 2 windows network_output is still 1; after the 3rd it is 2 with one class_update pulse.
- **Reset mid-window.** 5 samples of aux0=4000, then rst for 1 cycle, then 8 samples of aux0=800 -> avg_aux0=800 with no contamination from the earlier samples, and all outputs are 0 during and immediately after reset.
